cpu_ctrl_fsm: RTL and testbench

//  Multi-cycle sequencer for the 16-bit CPU datapath (regfile, alu, aluBuff bus driver, RAM, IMem).

---
 rtl/cpu_ctrl_fsm.sv | 214 +++++++++++++++++++++
 tb/tb_cpu_ctrl_fsm.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_ctrl_fsm.sv
`default_nettype none
// +-----------------------------------------------------------------------------------+
// | cpu_ctrl_fsm : multi-cycle fetch/decode/exec/mem/wb sequencer for the 16-bit CPU  |
// |                owns PC and IR; optional retired-instruction counter (CTRL_PERF_EN) |
// | Rev 1.0                                                                           |
// +-----------------------------------------------------------------------------------+
module cpu_ctrl_fsm #(
   parameter int PC_W   = 4,
   parameter int LINK_R = 15
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic [PC_W-1:0] imem_addr,
   input  logic [15:0]     imem_data,
   output logic [3:0]      rf_raddr_a,
   output logic [3:0]      rf_raddr_b,
   output logic [3:0]      rf_waddr,
   output logic            rf_we,
   output logic [1:0]      rf_wsel,
   output logic [2:0]      alu_sel,
   output logic            alu_b_imm,
   output logic            alu_a_zero,
   output logic [3:0]      shamt,
   output logic            en_alu,
   output logic            mem_we,
   output logic            mem_oe,
   output logic [3:0]      mem_addr,
   input  logic            mem_ready,
   input  logic            eq,
   input  logic [PC_W-1:0] br_target,
   output logic            disp_valid,
   output logic            halted,
   output logic [15:0]     retired_cnt
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd5
   } state_t;

   localparam logic [3:0] OP_ADDI = 4'h1;
   localparam logic [3:0] OP_SUBI = 4'h3;
   localparam logic [3:0] OP_DISP = 4'h7;
   localparam logic [3:0] OP_HALT = 4'h9;
   localparam logic [3:0] OP_BL   = 4'hB;
   localparam logic [3:0] OP_BEQ  = 4'hC;
   localparam logic [3:0] OP_B    = 4'hD;
   localparam logic [3:0] OP_STUR = 4'hE;
   localparam logic [3:0] OP_LDUR = 4'hF;

   state_t          state, state_nxt;
   logic [PC_W-1:0] pc, pc_nxt, pc_inc;
   logic [15:0]     ir;
   logic            beq_flag;
   logic [3:0]      op, rd, rn, rm;
   logic            is_alu;

   assign op     = ir[15:12];
   assign rd     = ir[11:8];
   assign rn     = ir[7:4];
   assign rm     = ir[3:0];
   assign pc_inc = pc + PC_W'(1);
   assign is_alu = (op <= 4'h6) || (op == 4'h8) || (op == 4'hA);

   // Opcode pairs 0/1 and 2/3 are reg/imm forms of ADD and SUB.
   function automatic logic [2:0] alu_code(input logic [3:0] o);
      case (o)
         4'h0, 4'h1: alu_code = 3'b000;
         4'h2, 4'h3: alu_code = 3'b001;
         4'h4:       alu_code = 3'b010;
         4'h5:       alu_code = 3'b011;
         4'h6:       alu_code = 3'b100;
         4'h8:       alu_code = 3'b110;
         4'hA:       alu_code = 3'b111;
         default:    alu_code = 3'b000;
      endcase
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_FETCH;
         pc       <= '0;
         ir       <= '0;
         beq_flag <= 1'b0;
      end else begin
         state <= state_nxt;
         pc    <= pc_nxt;
         if (state == S_FETCH)
            ir <= imem_data;
         if (state == S_DECODE)
            beq_flag <= eq;
      end
   end

   always_comb begin
      state_nxt  = state;
      pc_nxt     = pc;
      rf_waddr   = rd;
      rf_we      = 1'b0;
      rf_wsel    = 2'd0;
      alu_sel    = 3'b000;
      alu_b_imm  = 1'b0;
      alu_a_zero = 1'b0;
      en_alu     = 1'b0;
      mem_we     = 1'b0;
      mem_oe     = 1'b0;
      disp_valid = 1'b0;
      // BEQ compares Rn/Rm during DECODE, then reads its target from Rd in EXEC.
      rf_raddr_a = (op == OP_DISP || op == OP_BL || op == OP_B ||
                    (op == OP_BEQ && state != S_DECODE)) ? rd : rn;
      rf_raddr_b = (op == OP_STUR) ? rn : rm;

      case (state)
         S_FETCH:  state_nxt = S_DECODE;
         S_DECODE: state_nxt = (op == OP_HALT) ? S_HALT : S_EXEC;
         S_EXEC: begin
            if (is_alu) begin
               en_alu    = 1'b1;
               alu_sel   = alu_code(op);
               alu_b_imm = (op == OP_ADDI) || (op == OP_SUBI);
               state_nxt = S_WB;
            end else begin
               case (op)
                  OP_DISP: begin
                     disp_valid = 1'b1;
                     pc_nxt     = pc_inc;
                     state_nxt  = S_FETCH;
                  end
                  OP_BL:   state_nxt = S_WB;
                  OP_B: begin
                     pc_nxt    = br_target;
                     state_nxt = S_FETCH;
                  end
                  OP_BEQ: begin
                     pc_nxt    = beq_flag ? br_target : pc_inc;
                     state_nxt = S_FETCH;
                  end
                  OP_STUR: begin
                     alu_a_zero = 1'b1;
                     en_alu     = 1'b1;
                     state_nxt  = S_MEM;
                  end
                  OP_LDUR: state_nxt = S_MEM;
                  default: begin
                     pc_nxt    = pc_inc;
                     state_nxt = S_FETCH;
                  end
               endcase
            end
         end
         S_MEM: begin
            if (op == OP_STUR) begin
               alu_a_zero = 1'b1;
               en_alu     = 1'b1;
               mem_we     = 1'b1;
               if (mem_ready) begin
                  pc_nxt    = pc_inc;
                  state_nxt = S_FETCH;
               end
            end else begin
               mem_oe = 1'b1;
               if (mem_ready)
                  state_nxt = S_WB;
            end
         end
         S_WB: begin
            rf_we     = 1'b1;
            pc_nxt    = pc_inc;
            state_nxt = S_FETCH;
            if (op == OP_BL) begin
               rf_waddr = 4'(LINK_R);
               rf_wsel  = 2'd1;
               pc_nxt   = br_target;
            end else if (op == OP_LDUR) begin
               rf_waddr = rn;
               mem_oe   = 1'b1;
            end else begin
               // ALU result must stay on the bus through the write edge.
               en_alu    = 1'b1;
               alu_sel   = alu_code(op);
               alu_b_imm = (op == OP_ADDI) || (op == OP_SUBI);
            end
         end
         S_HALT:  state_nxt = S_HALT;
         default: state_nxt = S_FETCH;
      endcase
   end

   assign imem_addr = pc;
   assign shamt     = rm;
   assign mem_addr  = rd;
   assign halted    = (state == S_HALT);

`ifdef CTRL_PERF_EN
   logic [15:0] retired_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         retired_q <= 16'h0000;
      else if (state_nxt == S_FETCH && (state == S_EXEC || state == S_MEM || state == S_WB))
         retired_q <= retired_q + 16'd1;
   end

   assign retired_cnt = retired_q;
`else
   assign retired_cnt = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cpu_ctrl_fsm.sv
`default_nettype none
// tb_cpu_ctrl_fsm: table-driven single-instruction vectors plus multi-cycle sequences,
// against a small regfile/ALU/RAM datapath model with IMem held in an array.
module tb_cpu_ctrl_fsm;
   localparam int PC_W = 4;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [PC_W-1:0] imem_addr;
   logic [15:0]     imem_data;
   logic [3:0]      rf_raddr_a, rf_raddr_b, rf_waddr;
   logic            rf_we;
   logic [1:0]      rf_wsel;
   logic [2:0]      alu_sel;
   logic            alu_b_imm, alu_a_zero;
   logic [3:0]      shamt;
   logic            en_alu, mem_we, mem_oe;
   logic [3:0]      mem_addr;
   logic            mem_ready, eq;
   logic [PC_W-1:0] br_target;
   logic            disp_valid, halted;
   logic [15:0]     retired_cnt;

   always #5 clk = ~clk;

   cpu_ctrl_fsm #(.PC_W(PC_W), .LINK_R(15)) dut (
      .clk(clk), .rst_n(rst_n),
      .imem_addr(imem_addr), .imem_data(imem_data),
      .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b), .rf_waddr(rf_waddr),
      .rf_we(rf_we), .rf_wsel(rf_wsel),
      .alu_sel(alu_sel), .alu_b_imm(alu_b_imm), .alu_a_zero(alu_a_zero), .shamt(shamt),
      .en_alu(en_alu), .mem_we(mem_we), .mem_oe(mem_oe), .mem_addr(mem_addr),
      .mem_ready(mem_ready), .eq(eq), .br_target(br_target),
      .disp_valid(disp_valid), .halted(halted), .retired_cnt(retired_cnt)
   );

   // ---------------- datapath model ----------------
   logic [15:0] imem [16];
   logic [15:0] regs [16];
   logic [15:0] ram  [16];
   logic [15:0] alu_a, alu_b, alu_y, bus;
   logic [3:0]  pc1;
   int          stall_len;
   int          mem_wait;
   int          we_cnt, en_cnt, disp_cnt, memwe_cnt, oe_cnt;
   logic [15:0] disp_val;
   int          strobe_cnt   = 0;
   int          conflict_cnt = 0;

   assign imem_data = imem[imem_addr];
   assign pc1       = imem_addr + 4'd1;
   assign eq        = (regs[rf_raddr_a] == regs[rf_raddr_b]);
   assign br_target = regs[rf_raddr_a][3:0];
   assign mem_ready = (stall_len == 0) || (mem_wait >= stall_len);

   always_comb begin
      alu_a = alu_a_zero ? 16'h0000 : regs[rf_raddr_a];
      alu_b = alu_b_imm ? {12'h000, shamt} : regs[rf_raddr_b];
      case (alu_sel)
         3'b000:  alu_y = alu_a + alu_b;
         3'b001:  alu_y = alu_a - alu_b;
         3'b010:  alu_y = alu_a & alu_b;
         3'b011:  alu_y = alu_a | alu_b;
         3'b100:  alu_y = alu_a ^ alu_b;
         3'b110:  alu_y = ~(alu_a & alu_b);
         3'b111:  alu_y = alu_a << shamt;
         default: alu_y = 16'h0000;
      endcase
      bus = en_alu ? alu_y : (mem_oe ? ram[mem_addr] : 16'h0000);
   end

   always @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < 16; i++) begin
            regs[i] <= (i == 0) ? 16'h0000 : 16'(i * 7 + 3);
            ram[i]  <= 16'hA000 + 16'(i);
         end
         we_cnt <= 0; en_cnt <= 0; disp_cnt <= 0; memwe_cnt <= 0; oe_cnt <= 0;
         disp_val <= 16'h0000;
         mem_wait <= 0;
      end else begin
         if (rf_we)
            regs[rf_waddr] <= (rf_wsel == 2'd1) ? {12'h000, pc1} : bus;
         if (mem_we && mem_ready)
            ram[mem_addr] <= bus;
         if (rf_we)  we_cnt    <= we_cnt + 1;
         if (en_alu) en_cnt    <= en_cnt + 1;
         if (mem_we) memwe_cnt <= memwe_cnt + 1;
         if (mem_oe) oe_cnt    <= oe_cnt + 1;
         if (disp_valid) begin
            disp_cnt <= disp_cnt + 1;
            disp_val <= regs[rf_raddr_a];
         end
         if ((mem_we || (mem_oe && !rf_we)) && !mem_ready)
            mem_wait <= mem_wait + 1;
         else
            mem_wait <= 0;
      end
      if (rf_we || mem_we || mem_oe || en_alu || disp_valid)
         strobe_cnt <= strobe_cnt + 1;
      if (en_alu && mem_oe)
         conflict_cnt <= conflict_cnt + 1;
   end

   // ---------------- checking ----------------
   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic fill_halt();
      for (int i = 0; i < 16; i++) imem[i] = 16'h9000;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic run_until_halt(input int budget, output int cyc);
      cyc = -1;
      for (int c = 1; c <= budget; c++) begin
         @(posedge clk);
         #1;
         if (halted) begin
            cyc = c;
            break;
         end
      end
   endtask

   typedef struct {
      string       name;
      logic [15:0] instr;
      int          lat;
      logic [3:0]  pc_end;
      int          we;
      int          en;
      int          disp;
      int          kind;   // 0: register, 1: RAM word, 2: displayed value
      logic [3:0]  idx;
      logic [15:0] val;
   } vec_t;

   vec_t vt [16];
   int   cyc;
   logic [15:0] got;
   logic [3:0]  pc_snap;
   int          strobe_snap;

   initial begin
      // Preset: R0=0, Rn=7n+3; RAM[n]=A000+n. Every other IMem word is HALT.
      vt[0]  = '{"ADD",     16'h0312, 4, 4'd1,  1, 2, 0, 0, 4'd3,  16'd27};
      vt[1]  = '{"ADDI",    16'h1416, 4, 4'd1,  1, 2, 0, 0, 4'd4,  16'd16};
      vt[2]  = '{"SUB",     16'h2521, 4, 4'd1,  1, 2, 0, 0, 4'd5,  16'd7};
      vt[3]  = '{"SUBI",    16'h3622, 4, 4'd1,  1, 2, 0, 0, 4'd6,  16'd15};
      vt[4]  = '{"AND",     16'h4723, 4, 4'd1,  1, 2, 0, 0, 4'd7,  16'd16};
      vt[5]  = '{"OR",      16'h5812, 4, 4'd1,  1, 2, 0, 0, 4'd8,  16'd27};
      vt[6]  = '{"XOR",     16'h6923, 4, 4'd1,  1, 2, 0, 0, 4'd9,  16'd9};
      vt[7]  = '{"NAND",    16'h8A12, 4, 4'd1,  1, 2, 0, 0, 4'd10, 16'hFFFF};
      vt[8]  = '{"LSL",     16'hAB13, 4, 4'd1,  1, 2, 0, 0, 4'd11, 16'd80};
      vt[9]  = '{"DISP",    16'h7200, 3, 4'd1,  0, 0, 1, 2, 4'd0,  16'd17};
      vt[10] = '{"BEQ_eq",  16'hC311, 3, 4'd8,  0, 0, 0, 0, 4'd3,  16'd24};
      vt[11] = '{"BEQ_ne",  16'hC312, 3, 4'd1,  0, 0, 0, 0, 4'd3,  16'd24};
      vt[12] = '{"B",       16'hD500, 3, 4'd6,  0, 0, 0, 0, 4'd5,  16'd38};
      vt[13] = '{"BL",      16'hB600, 4, 4'd13, 1, 0, 0, 0, 4'd15, 16'd1};
      vt[14] = '{"STUR",    16'hE420, 4, 4'd1,  0, 2, 0, 1, 4'd4,  16'd17};
      vt[15] = '{"LDUR",    16'hF550, 5, 4'd1,  1, 0, 0, 0, 4'd5,  16'hA005};

      stall_len = 0;
      fill_halt();
      rst_n = 1'b0;
      #1;
      chk("reset_strobes", 32'({rf_we, en_alu, mem_we, mem_oe, disp_valid, halted, alu_sel}), 32'd0);
      chk("reset_pc", 32'(imem_addr), 32'd0);
      chk("reset_retired", 32'(retired_cnt), 32'd0);

      for (int i = 0; i < 16; i++) begin
         fill_halt();
         imem[0] = vt[i].instr;
         do_reset();
         run_until_halt(40, cyc);
         chk({vt[i].name, "_latency"}, 32'(cyc), 32'(vt[i].lat + 2));
         chk({vt[i].name, "_pc"}, 32'(imem_addr), 32'(vt[i].pc_end));
         chk({vt[i].name, "_rf_we"}, 32'(we_cnt), 32'(vt[i].we));
         chk({vt[i].name, "_en_alu"}, 32'(en_cnt), 32'(vt[i].en));
         chk({vt[i].name, "_disp"}, 32'(disp_cnt), 32'(vt[i].disp));
         case (vt[i].kind)
            0:       got = regs[vt[i].idx];
            1:       got = ram[vt[i].idx];
            default: got = disp_val;
         endcase
         chk({vt[i].name, "_value"}, 32'(got), 32'(vt[i].val));
      end

      // Five-instruction program ending in HALT.
      fill_halt();
      imem[0] = 16'h1105; imem[1] = 16'h0211; imem[2] = 16'h7200;
      imem[3] = 16'hE120; imem[4] = 16'h0311;
      do_reset();
      run_until_halt(60, cyc);
      chk("prog_latency", 32'(cyc), 32'd21);
      chk("prog_disp_val", 32'(disp_val), 32'd10);
      chk("prog_disp_cnt", 32'(disp_cnt), 32'd1);
      chk("prog_ram1", 32'(ram[1]), 32'd10);
      chk("prog_r3", 32'(regs[3]), 32'd10);
`ifdef CTRL_PERF_EN
      chk("retired_cnt", 32'(retired_cnt), 32'd5);
`else
      chk("retired_cnt", 32'(retired_cnt), 32'd0);
`endif

      // STUR then LDUR with RAM holding off 3 cycles each.
      fill_halt();
      imem[0] = 16'hE720; imem[1] = 16'hF793;
      stall_len = 3;
      do_reset();
      run_until_halt(60, cyc);
      stall_len = 0;
      chk("stall_latency", 32'(cyc), 32'd17);
      chk("stall_ram7", 32'(ram[7]), 32'd17);
      chk("stall_r9", 32'(regs[9]), 32'd17);
      chk("stall_rf_we", 32'(we_cnt), 32'd1);
      chk("stall_mem_we", 32'(memwe_cnt), 32'd4);
      chk("stall_mem_oe", 32'(oe_cnt), 32'd5);

      // Reset asserted while ADD is in EXEC.
      fill_halt();
      imem[0] = 16'h0312;
      do_reset();
      repeat (2) begin @(posedge clk); #1; end
      chk("midexec_en_alu", 32'(en_alu), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("midexec_strobes", 32'({rf_we, en_alu, mem_we}), 32'd0);
      chk("midexec_pc", 32'(imem_addr), 32'd0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      run_until_halt(40, cyc);
      chk("midexec_rerun", 32'(cyc), 32'd6);
      chk("midexec_r3", 32'(regs[3]), 32'd27);

      // HALT is terminal and quiet until reset.
      #1;
      pc_snap     = imem_addr;
      strobe_snap = strobe_cnt;
      repeat (100) @(posedge clk);
      #1;
      chk("halt_strobes", 32'(strobe_cnt - strobe_snap), 32'd0);
      chk("halt_pc", 32'(imem_addr), 32'(pc_snap));
      chk("halt_sticky", 32'(halted), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("halt_cleared", 32'(halted), 32'd0);

      // BL from PC=15: link wraps to 0.
      fill_halt();
      imem[0] = 16'hD400; imem[15] = 16'hB500;
      do_reset();
      run_until_halt(40, cyc);
      chk("blwrap_latency", 32'(cyc), 32'd9);
      chk("blwrap_pc", 32'(imem_addr), 32'd6);
      chk("blwrap_r15", 32'(regs[15]), 32'd0);
      chk("blwrap_rf_we", 32'(we_cnt), 32'd1);

      chk("bus_single_driver", 32'(conflict_cnt), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
